sequence_generator: RTL and testbench
=====================================

SEQUENCE_GENERATOR -- requirements
Module: sequence_generator

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the maximum frame length in bits (legal range 2..16).
REQ-002 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 load  input  1  request to start a frame; sampled only while ready=1.
REQ-005 data  input  WIDTH  pattern to serialise; bit WIDTH-1 SHALL be sent first.
REQ-006 len  input  $clog2(WIDTH+1)  number of bits to send; 0 and values above WIDTH SHALL mean WIDTH.
REQ-007 abort  input  1  synchronous cancel of the frame in progress.
REQ-008 x  output  1  serial bit stream, registered.
REQ-009 x_valid  output  1  high while x carries a frame bit.
REQ-010 ready  output  1  high only in IDLE.
REQ-011 done  output  1  one-cycle pulse after a frame completes.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT, PARITY and DONE.
REQ-013 IDLE: ready=1, x=0, x_valid=0; load=1 and abort=0 SHALL capture data and the effective len, then go to SHIFT.
REQ-014 Latency: the first bit (data[WIDTH-1]) SHALL appear on x in the cycle after load is sampled.
REQ-015 SHIFT: each cycle SHALL emit the next bit MSB-first with x_valid=1; exactly len bits SHALL be emitted, namely data[WIDTH-1] down to data[WIDTH-len].
REQ-016 After the last data bit, the FSM SHALL go to PARITY if PARITY_EN is defined and to DONE otherwise.
REQ-017 PARITY: one cycle, with x set to the XOR of all emitted data bits (even parity) and x_valid=1.
REQ-018 DONE: one cycle, with done=1, x=0, x_valid=0 and ready=0; the FSM SHALL then return to IDLE.
REQ-019 load while ready=0 SHALL be ignored and SHALL have no effect on the frame in progress.
REQ-020 abort=1 in SHIFT or PARITY SHALL force IDLE at the next edge, with x=0, x_valid=0 and no done pulse.
REQ-021 abort=1 and load=1 together in IDLE: abort SHALL win, and no frame SHALL start.
REQ-022 abort in DONE SHALL be ignored; the done pulse SHALL still occur.
REQ-023 Back-to-back frames: the minimum gap between the last frame bit and the next frame's first bit SHALL be 2 cycles (DONE, then IDLE).
REQ-024 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap within a frame.
REQ-025 Changes to data and len after capture SHALL NOT affect the frame in progress.

Reset
REQ-026 reset=0 SHALL immediately force IDLE, x=0, x_valid=0, done=0, ready=1, and clear the shift register and counter, regardless of clock.
REQ-027 Reset asserted mid-frame SHALL abandon the frame without a done pulse.
REQ-028 The first load SHALL be accepted at the first rising edge after reset deasserts.

Configuration
REQ-029 Macro SEQUENCE_GENERATOR_PARITY_EN defined: the PARITY state SHALL exist and each frame SHALL be len+1 bits long.
REQ-030 Macro undefined: no PARITY state or parity logic SHALL be present; frames SHALL be len bits and SHIFT SHALL go directly to DONE.

Verification
REQ-031 WIDTH=8, data=8'b1011_0010, len=0, no parity -> x=1,0,1,1,0,0,1,0 on 8 consecutive cycles with x_valid=1, then done=1 for one cycle.
REQ-032 data=8'hA5, len=4, PARITY_EN defined -> x=1,0,1,0, then parity bit 0; done pulses on cycle 6 after load.
REQ-033 data=8'hFF, len=3, PARITY_EN defined -> x=1,1,1, then parity bit 1.
REQ-034 abort on the 3rd SHIFT cycle of an 8-bit frame -> the next cycle shows IDLE, ready=1, x_valid=0, and done never pulses.
REQ-035 reset pulsed low mid-frame -> outputs go to reset values without waiting for clock; load=1 right after release starts a new frame one cycle later.
REQ-036 load held high continuously with data=8'h81, len=2 -> frames 1,0 repeat with a 2-cycle gap, and load during SHIFT is ignored.

Source files
------------

// File: rtl/sequence_generator.sv
// sequence_generator
// Serialises a captured WIDTH-bit pattern MSB-first, emitting len bits
// (0 or anything above WIDTH means WIDTH). Frames run IDLE -> SHIFT -> DONE.
// Optional feature macro: SEQUENCE_GENERATOR_PARITY_EN. When it is defined, a
// PARITY state after SHIFT appends one even-parity bit to each frame.
//
// Ports:
//   clk_i      rising-edge clock
//   rst_ni     asynchronous active-low reset
//   load_i     start a frame (sampled only while ready_o=1)
//   data_i     pattern, bit WIDTH-1 sent first
//   len_i      bit count (0 / >WIDTH => WIDTH)
//   abort_i    synchronous cancel of the frame in progress (also blocks a load)
//   x_o        registered serial bit
//   x_valid_o  x_o carries a frame bit
//   ready_o    FSM is idle and will accept a load
//   done_o     one-cycle pulse after a completed frame
module sequence_generator #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [CW-1:0]    len_i,
  input  logic             abort_i,
  output logic             x_o,
  output logic             x_valid_o,
  output logic             ready_o,
  output logic             done_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
`ifdef SEQUENCE_GENERATOR_PARITY_EN
    S_PARITY = 2'd2,
`endif
    S_DONE   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;    // bits still to send, next one at MSB
  logic [CW-1:0]    cnt_q, cnt_d;  // bits remaining after the one on x_o
  logic             x_q, x_d;
`ifdef SEQUENCE_GENERATOR_PARITY_EN
  logic             par_q, par_d;  // running XOR of bits already emitted
`endif

  logic [CW-1:0] len_eff;
  assign len_eff = (len_i == '0 || len_i > CW'(WIDTH)) ? CW'(WIDTH) : len_i;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    x_d     = 1'b0;
`ifdef SEQUENCE_GENERATOR_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (load_i && !abort_i) begin
          // First bit goes straight onto x so it appears the cycle after load.
          state_d = S_SHIFT;
          x_d     = data_i[WIDTH-1];
          sr_d    = {data_i[WIDTH-2:0], 1'b0};
          cnt_d   = len_eff - CW'(1);
`ifdef SEQUENCE_GENERATOR_PARITY_EN
          par_d   = data_i[WIDTH-1];
`endif
        end
      end
      S_SHIFT: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
`ifdef SEQUENCE_GENERATOR_PARITY_EN
          state_d = S_PARITY;
          x_d     = par_q;
`else
          state_d = S_DONE;
`endif
        end else begin
          x_d   = sr_q[WIDTH-1];
          sr_d  = {sr_q[WIDTH-2:0], 1'b0};
          cnt_d = cnt_q - CW'(1);
`ifdef SEQUENCE_GENERATOR_PARITY_EN
          par_d = par_q ^ sr_q[WIDTH-1];
`endif
        end
      end
`ifdef SEQUENCE_GENERATOR_PARITY_EN
      S_PARITY: state_d = abort_i ? S_IDLE : S_DONE;
`endif
      S_DONE:  state_d = S_IDLE;  // abort is deliberately ignored here
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      x_q     <= 1'b0;
`ifdef SEQUENCE_GENERATOR_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
`ifdef SEQUENCE_GENERATOR_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign x_o       = x_q;
`ifdef SEQUENCE_GENERATOR_PARITY_EN
  assign x_valid_o = (state_q == S_SHIFT) || (state_q == S_PARITY);
`else
  assign x_valid_o = (state_q == S_SHIFT);
`endif
  assign ready_o   = (state_q == S_IDLE);
  assign done_o    = (state_q == S_DONE);

endmodule

// File: tb/tb_sequence_generator.sv
module tb_sequence_generator;
  localparam int W  = 8;
  localparam int LW = $clog2(W + 1);
`ifdef SEQUENCE_GENERATOR_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load, abort;
  logic [W-1:0]  data;
  logic [LW-1:0] len;
  logic          x, x_valid, ready, done;

  int n_cmp = 0;
  int n_err = 0;

  sequence_generator #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .load_i(load), .data_i(data), .len_i(len),
    .abort_i(abort), .x_o(x), .x_valid_o(x_valid), .ready_o(ready), .done_o(done)
  );

  always #5 clk = ~clk;

  function automatic int eff_len(input int l);
    return (l == 0 || l > W) ? W : l;
  endfunction

  // Runs one frame from IDLE and checks every cycle {x,x_valid,done,ready}
  // against the frame shape: L data bits, optional parity, DONE, IDLE.
  // junk=1 scribbles on load/data/len while the frame is busy.
  task automatic play_frame(input logic [W-1:0] d, input int l, input bit junk);
    int L, total;
    logic par;
    logic [3:0] obs, exp;
    L = eff_len(l);
    total = L + PAR;
    par = 1'b0;
    for (int i = 0; i < L; i++) par ^= d[W-1-i];
    load = 1'b1; data = d; len = LW'(l); abort = 1'b0;
    for (int k = 1; k <= total + 2; k++) begin
      @(posedge clk); #1;
      if (junk && k <= total) begin
        load = 1'($urandom); data = W'($urandom); len = LW'($urandom);
      end else load = 1'b0;
      if (k <= L)          exp = {d[W-k], 1'b1, 1'b0, 1'b0};
      else if (k <= total) exp = {par, 1'b1, 1'b0, 1'b0};
      else if (k == total + 1) exp = 4'b0010;
      else                 exp = 4'b0001;
      obs = {x, x_valid, done, ready};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL frame d=%h len=%0d cyc=%0d: got {x,xv,done,rdy}=%b want %b", d, l, k, obs, exp);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load = 1'b1; abort = 1'b0; data = 8'hFF; len = '0;
    #2;
    n_cmp++;
    if ({x, x_valid, done, ready} !== 4'b0001) begin
      n_err++; $display("FAIL reset_state: got %b want 0001", {x, x_valid, done, ready});
    end
    @(posedge clk); @(posedge clk); #1;
    n_cmp++;
    if ({x, x_valid, done, ready} !== 4'b0001) begin
      n_err++; $display("FAIL reset_held_load: got %b want 0001", {x, x_valid, done, ready});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    play_frame(8'b1011_0010, 0, 1'b0);
    play_frame(8'hA5, 4, 1'b0);
    play_frame(8'hFF, 3, 1'b0);
    play_frame(8'h40, 1, 1'b0);
    play_frame(8'h3C, 15, 1'b0);  // above WIDTH means WIDTH
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++)
      play_frame(W'($urandom), int'($urandom_range(0, 15)), 1'b1);
  endtask

  task automatic test_abort(input int at_cyc);
    int seen_done = 0;
    load = 1'b1; data = 8'hB7; len = '0; abort = 1'b0;
    for (int k = 1; k <= at_cyc; k++) begin
      @(posedge clk); #1;
      load = 1'b0;
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    n_cmp++;
    if ({x, x_valid, ready} !== 3'b001) begin
      n_err++; $display("FAIL abort_at_%0d: got {x,xv,rdy}=%b want 001", at_cyc, {x, x_valid, ready});
    end
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done) seen_done++;
    end
    n_cmp++;
    if (seen_done != 0) begin
      n_err++; $display("FAIL abort_no_done: got %0d done pulses want 0", seen_done);
    end
  endtask

  task automatic test_abort_load_idle();
    load = 1'b1; abort = 1'b1; data = 8'hFF; len = '0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({x, x_valid, done, ready} !== 4'b0001) begin
        n_err++; $display("FAIL abort_vs_load: got %b want 0001", {x, x_valid, done, ready});
      end
    end
    load = 1'b0; abort = 1'b0;
  endtask

  task automatic test_reset_midframe();
    load = 1'b1; data = 8'hF0; len = '0; abort = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      load = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({x, x_valid, done, ready} !== 4'b0001) begin
      n_err++; $display("FAIL reset_midframe_async: got %b want 0001", {x, x_valid, done, ready});
    end
    #2 rst_n = 1'b1;
    play_frame(8'h9D, 5, 1'b0);
  endtask

  task automatic test_back_to_back();
    localparam logic [W-1:0] D = 8'h81;
    int period;
    logic [3:0] obs, exp;
    period = 2 + PAR + 2;
    load = 1'b1; data = D; len = LW'(2); abort = 1'b0;
    for (int k = 0; k < 3 * period; k++) begin
      @(posedge clk); #1;
      if (k == 3 * period - 2) load = 1'b0;
      case (k % period)
        0: exp = 4'b1100;
        1: exp = 4'b0100;
        default: begin
          if (PAR == 1 && (k % period) == 2) exp = 4'b1100;  // 1^0
          else if ((k % period) == period - 2) exp = 4'b0010;
          else exp = 4'b0001;
        end
      endcase
      obs = {x, x_valid, done, ready};
      n_cmp++;
      if (obs !== exp) begin
        n_err++; $display("FAIL back_to_back cyc=%0d: got %b want %b", k, obs, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_abort(3);
    test_abort(8);
    test_abort_load_idle();
    test_reset_midframe();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
